// File: rtl/forth_pkg.sv
// rtl/forth_pkg.sv - shared constants for the Forth data-bus responder
package forth_pkg;
    // I/O page offsets, each subtracted from 2**DADDR_WIDTH
    localparam int IO_TXDATA = 4;
    localparam int IO_RXDATA = 3;
    localparam int IO_STATUS = 2;
    localparam int IO_TIMER  = 1;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVF   = 5;

    localparam int RX_VALID_BIT = 15;
endpackage

// File: rtl/forth_io_fifo.sv
// rtl/forth_io_fifo.sv - show-ahead synchronous byte FIFO for the I/O page
module forth_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // Pop is inhibited when empty; a push into a full FIFO survives only alongside a pop.
    assign do_pop  = pop & (cnt != '0);
    assign do_push = push & ((cnt != (AW+1)'(DEPTH)) | do_pop);

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/forth_dbus_responder.sv
// rtl/forth_dbus_responder.sv - word RAM plus memory-mapped TX/RX/status/timer page
module forth_dbus_responder
    import forth_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DADDR_WIDTH = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DADDR_WIDTH-1:0] daddr,
    input  logic [WIDTH-1:0]       ddata_write,
    input  logic                   dwrite,
    output logic [WIDTH-1:0]       ddata_read,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready
);
    localparam int TOP = 2 ** DADDR_WIDTH;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DADDR_WIDTH-1:0] A_TX = DADDR_WIDTH'(TOP - IO_TXDATA);
    localparam logic [DADDR_WIDTH-1:0] A_RX = DADDR_WIDTH'(TOP - IO_RXDATA);
    localparam logic [DADDR_WIDTH-1:0] A_ST = DADDR_WIDTH'(TOP - IO_STATUS);
    localparam logic [DADDR_WIDTH-1:0] A_TM = DADDR_WIDTH'(TOP - IO_TIMER);

    logic [WIDTH-1:0] mem [TOP];
    logic [WIDTH-1:0] timer;
    logic [WIDTH-1:0] rd_mux;
    logic             tx_ovf, rx_ovf;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]    tx_count, rx_count;
    logic [7:0]       rx_dout;
    logic             is_ram, is_tx, is_rx, is_st, is_tm;
    logic             tx_push, tx_pop, rx_push, rx_pop, st_clr;

    assign is_ram = (daddr < A_TX);
    assign is_tx  = (daddr == A_TX);
    assign is_rx  = (daddr == A_RX);
    assign is_st  = (daddr == A_ST);
    assign is_tm  = (daddr == A_TM);

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign tx_push  = dwrite & is_tx;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = is_rx & !dwrite & (rx_count != '0);
    assign st_clr   = dwrite & is_st;

    forth_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(ddata_write[7:0]),
        .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    forth_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_data),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        rd_mux = '0;
        if (is_ram) begin
            rd_mux = mem[daddr];
        end else if (is_tx) begin
            rd_mux = WIDTH'(tx_count);
        end else if (is_rx) begin
            if (!rx_empty) begin
                rd_mux[7:0]          = rx_dout;
                rd_mux[RX_VALID_BIT] = 1'b1;
            end
        end else if (is_st) begin
            rd_mux[ST_TX_FULL]  = tx_full;
            rd_mux[ST_TX_EMPTY] = tx_empty;
            rd_mux[ST_RX_FULL]  = rx_full;
            rd_mux[ST_RX_EMPTY] = rx_empty;
            rd_mux[ST_TX_OVF]   = tx_ovf;
            rd_mux[ST_RX_OVF]   = rx_ovf;
        end else if (is_tm) begin
            rd_mux = timer;
        end
    end

    // Sticky bits: a set in the same cycle as a software clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ddata_read <= '0;
            timer      <= '0;
            tx_ovf     <= 1'b0;
            rx_ovf     <= 1'b0;
        end else begin
            ddata_read <= rd_mux;
            timer      <= (dwrite & is_tm) ? ddata_write + WIDTH'(1) : timer + WIDTH'(1);
            tx_ovf     <= (tx_push & tx_full & !tx_pop) | (tx_ovf & !(st_clr & ddata_write[ST_TX_OVF]));
            rx_ovf     <= (rx_valid & rx_full) | (rx_ovf & !(st_clr & ddata_write[ST_RX_OVF]));
        end
    end

    always_ff @(posedge clk) begin
        if (dwrite & is_ram) mem[daddr] <= ddata_write;
    end
endmodule

// File: tb/tb_forth_dbus_responder.sv
// tb/tb_forth_dbus_responder.sv - scoreboard bench with behavioural model of the responder
module tb_forth_dbus_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  daddr;
    logic [15:0] ddata_write;
    logic        dwrite;
    logic [15:0] ddata_read;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    always #5 clk = ~clk;

    forth_dbus_responder dut (
        .clk(clk), .reset(reset), .daddr(daddr), .ddata_write(ddata_write),
        .dwrite(dwrite), .ddata_read(ddata_read), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    typedef struct {
        int          cyc;
        logic [15:0] val;
        bit          chk;
    } rd_t;

    rd_t         rd_q[$];
    logic [7:0]  tx_exp[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          exp_ok = 1'b0;
    bit          exp_txv, exp_rxr;

    logic [15:0] m_mem [256];
    bit          m_known [256];
    logic [7:0]  m_tx[$];
    logic [7:0]  m_rx[$];
    bit          m_txo, m_rxo, m_ok;
    logic [15:0] m_timer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive inputs, record expectations from the pre-edge model, then advance the model.
    task automatic step(input bit rst, input logic [7:0] a, input bit we, input logic [15:0] wd,
                        input bit txr_in, input bit rxv, input logic [7:0] rxd);
        logic [15:0] rv;
        bit          chk, txr, txpop, rxpop, txfull, rxfull, txo_set, rxo_set;
        txr = rst ? 1'b0 : txr_in;
        @(posedge clk);
        #2;
        reset = rst; daddr = a; dwrite = we; ddata_write = wd;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        cyc++;
        exp_ok  = m_ok;
        exp_txv = (m_tx.size() > 0);
        exp_rxr = (m_rx.size() < 16);

        rv = 16'h0;
        chk = m_ok;
        if (rst) begin
            chk = 1'b1;
        end else if (a < 8'd252) begin
            rv = m_mem[a]; chk = m_known[a];
        end else if (a == 8'd252) begin
            rv = 16'(m_tx.size());
        end else if (a == 8'd253) begin
            if (m_rx.size() > 0) rv = 16'h8000 | 16'(m_rx[0]);
        end else if (a == 8'd254) begin
            rv = {10'd0, m_rxo, m_txo, m_rx.size() == 0, m_rx.size() == 16,
                  m_tx.size() == 0, m_tx.size() == 16};
        end else begin
            rv = m_timer;
        end
        rd_q.push_back('{cyc, rv, chk});

        if (we && a < 8'd252) begin
            m_mem[a] = wd; m_known[a] = 1'b1;
        end
        if (rst) begin
            m_tx.delete(); m_rx.delete(); tx_exp.delete();
            m_txo = 0; m_rxo = 0; m_timer = 16'h0; m_ok = 1'b1;
            return;
        end
        txfull = (m_tx.size() == 16);
        rxfull = (m_rx.size() == 16);
        txpop  = (m_tx.size() > 0) && txr;
        rxpop  = (a == 8'd253) && !we && (m_rx.size() > 0);
        txo_set = 0; rxo_set = 0;
        if (txpop) void'(m_tx.pop_front());
        if (we && a == 8'd252) begin
            if (!txfull || txpop) begin
                m_tx.push_back(wd[7:0]); tx_exp.push_back(wd[7:0]);
            end else txo_set = 1;
        end
        if (rxpop) void'(m_rx.pop_front());
        if (rxv) begin
            if (!rxfull) m_rx.push_back(rxd);
            else rxo_set = 1;
        end
        if (we && a == 8'd254) begin
            if (wd[4]) m_txo = 0;
            if (wd[5]) m_rxo = 0;
        end
        if (txo_set) m_txo = 1;
        if (rxo_set) m_rxo = 1;
        m_timer = (we && a == 8'd255) ? wd + 16'd1 : m_timer + 16'd1;
    endtask

    // Monitor: ddata_read at this negedge answers the previous cycle's address.
    always @(negedge clk) begin
        rd_t r;
        logic [7:0] b;
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            r = rd_q.pop_front();
            if (r.chk && r.cyc == cyc - 1) check("ddata_read", 32'(ddata_read), 32'(r.val));
        end
        if (exp_ok) begin
            check("tx_valid", 32'(tx_valid), 32'(exp_txv));
            check("rx_ready", 32'(rx_ready), 32'(exp_rxr));
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() == 0) begin
                    check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    b = tx_exp.pop_front();
                    check("tx_data", 32'(tx_data), 32'(b));
                end
            end
        end
    end

    initial begin
        logic [7:0] a;
        reset = 1; daddr = 0; dwrite = 0; ddata_write = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        m_ok = 0; m_txo = 0; m_rxo = 0; m_timer = 0;
        for (int i = 0; i < 256; i++) m_known[i] = 0;

        step(1, 8'd254, 0, 0, 0, 0, 0);
        step(1, 8'd254, 0, 0, 0, 0, 0);
        step(0, 8'd254, 0, 0, 0, 0, 0);
        step(0, 8'd252, 0, 0, 0, 0, 0);

        step(0, 8'd5, 1, 16'h1234, 0, 0, 0);
        step(0, 8'd5, 1, 16'hBEEF, 0, 0, 0);
        step(0, 8'd5, 0, 16'h0, 0, 0, 0);
        step(0, 8'd5, 0, 16'h0, 0, 0, 0);

        for (int i = 0; i < 17; i++) step(0, 8'd252, 1, 16'(8'h41 + i), 0, 0, 0);
        step(0, 8'd252, 0, 0, 0, 0, 0);
        step(0, 8'd254, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 8'd5, 0, 0, 1, 0, 0);

        step(0, 8'd5, 0, 0, 0, 1, 8'h7A);
        step(0, 8'd253, 0, 0, 0, 0, 0);
        step(0, 8'd253, 0, 0, 0, 0, 0);
        step(0, 8'd254, 0, 0, 0, 0, 0);

        for (int i = 0; i < 17; i++) step(0, 8'd5, 0, 0, 0, 1, 8'($urandom));
        step(0, 8'd254, 0, 0, 0, 0, 0);
        step(0, 8'd254, 1, 16'h0020, 0, 0, 0);
        step(0, 8'd254, 0, 0, 0, 0, 0);

        step(0, 8'd255, 1, 16'hFFFE, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'd255, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) step(0, 8'd252, 1, 16'(8'hC0 + i), 0, 0, 0);
        step(1, 8'd255, 0, 0, 0, 0, 0);
        step(0, 8'd255, 0, 0, 0, 0, 0);
        step(0, 8'd254, 0, 0, 0, 0, 0);
        step(0, 8'd5, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 5) a = 8'(252 + $urandom_range(0, 3));
            else a = 8'($urandom_range(0, 7));
            step($urandom_range(0, 299) == 0, a, $urandom_range(0, 2) == 0, 16'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 8'($urandom));
        end

        for (int i = 0; i < 40; i++) step(0, 8'd5, 0, 0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("tx_drained", 32'(tx_exp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/forth_dbus_responder.md
Name: forth_dbus_responder

Overview:
Data-bus responder for the Forth core's data port. It serves the daddr/ddata_write/ddata_read/dwrite interface from a local word RAM and, in the top four addresses, from a memory-mapped I/O page. The I/O page contains:
- a byte TX FIFO
- a byte RX FIFO
- a status register
- a free-running timer

It sits between the core's data port and the board-level byte streams.

Parameters:
- WIDTH, 16, data word width; must match the core.
- DADDR_WIDTH, 8, data address width; must match the core.
- FIFO_DEPTH, 16, entries per byte FIFO; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- daddr  input  DADDR_WIDTH  data address from the core.
- ddata_write  input  WIDTH  write data from the core.
- dwrite  input  1  write enable; write commits on the rising edge where it is 1.
- ddata_read  output  WIDTH  registered read data.
- tx_data  output  8  head of TX FIFO.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  consumer accepts tx_data when tx_valid & tx_ready.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  incoming byte present.
- rx_ready  output  1  RX FIFO not full.

Behaviour:
- One clock; reset is synchronous and active-high. Clock is named clk, reset is named reset.
- Address map, with TOP = 2**DADDR_WIDTH:
  - RAM: 0..TOP-5.
  - TXDATA: TOP-4.
  - RXDATA: TOP-3.
  - STATUS: TOP-2.
  - TIMER: TOP-1.
- Read latency is 1 cycle. ddata_read in cycle n+1 reflects daddr in cycle n. The read is evaluated every cycle regardless of dwrite.
- Reset values:
  - ddata_read = 0, tx_valid = 0, rx_ready = 1.
  - Both FIFOs empty; TIMER = 0; sticky bits = 0.
  - RAM contents are not reset.
- RAM:
  - Write: mem[daddr] <= ddata_write.
  - Read-during-write to the same address returns the OLD data.
- TXDATA:
  - Write pushes ddata_write[7:0].
  - Read returns the TX occupancy count, zero-extended.
  - Write while full is dropped and sets tx_ovf.
- RXDATA:
  - Read returns {valid, 7'b0, byte}, where valid = !rx_empty; it returns 0 when empty.
  - A pop occurs on every cycle with daddr == RXDATA, !dwrite and !rx_empty.
  - Writes are ignored.
- STATUS, read:
  - bit0 tx_full
  - bit1 tx_empty
  - bit2 rx_full
  - bit3 rx_empty
  - bit4 tx_ovf (sticky)
  - bit5 rx_ovf (sticky)
  - other bits 0
- STATUS, write: a 1 in bit4/bit5 clears the corresponding sticky bit; other bits are ignored.
- TIMER:
  - Increments every cycle and wraps from all-ones to 0.
  - Write loads ddata_write; the next cycle reads back load+1 (no increment in the load cycle).
- RX push:
  - rx_valid & rx_ready pushes rx_data.
  - rx_valid while full does not push and sets rx_ovf once per cycle.
- FIFO rules:
  - Simultaneous push and pop on a full FIFO: both occur and the count is unchanged. For TX this applies only when the core writes while the consumer drains.
  - Simultaneous push and pop on an empty FIFO: push only; pop is inhibited.
  - A sticky-bit set and a software clear in the same cycle: set wins.
- Counts are log2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-transfer: FIFO contents are discarded and pointers are zeroed in that cycle; any in-flight push or pop is lost.

Decomposition:
- Shared package forth_pkg holds:
  - Offsets of the I/O page: IO_TXDATA=4, IO_RXDATA=3, IO_STATUS=2, IO_TIMER=1, each subtracted from TOP.
  - STATUS bit indices.
  - The RXDATA valid bit index (15).
- One sub-module: forth_io_fifo.
  - Synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout (show-ahead), full, empty, count.
  - Instantiated twice: TX and RX.
- RAM, decode, timer and status logic live in forth_dbus_responder.

Test Plan:
1. RAM: write 0x1234 to address 5, then 0xBEEF to address 5 with a same-cycle read of 5 → ddata_read=0x1234 next cycle; a subsequent read gives 0xBEEF.
2. TX: tx_ready=0, write 0x41..0x50 (16 bytes) then 0x51 → TXDATA reads 16, STATUS = 0x0011 (tx_full, tx_ovf). Then tx_ready=1 → bytes 0x41..0x50 appear in order and 0x51 never appears.
3. RX: push 0x7A via rx_valid, read RXDATA → 0x807A; the next RXDATA read returns 0x0000 and STATUS bit3=1.
4. RX overflow: push 17 bytes with no reads → rx_ready=0 after 16 pushes, rx_ovf=1. Writing STATUS=0x0020 → rx_ovf=0.
5. Timer: write TIMER=0xFFFE → reads over the following cycles give 0xFFFF, 0x0000, 0x0001.
6. Reset mid-stream: with TX holding 3 bytes, assert reset for 1 cycle → tx_valid=0, ddata_read=0, TIMER=0, and STATUS reads 0x000A.
